// File: rtl/board_sequencer_pkg.sv
// Shared definitions for the battleship board: tile, command and response
// codes plus default board dimensions. Also used by the video side
// (dynamic_screen) so both agree on the RAM tile encoding.
package board_sequencer_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 10;
    localparam int MAX_LEN_DEF = 5;
    localparam int ADDR_W      = 10;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_HIT   = 2'd1,
        TILE_MISS  = 2'd2,
        TILE_SHIP  = 2'd3
    } tile_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_PLACE = 2'd1,
        OP_FIRE  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        RSP_DONE  = 2'd0,
        RSP_HIT   = 2'd1,
        RSP_MISS  = 2'd2,
        RSP_ERROR = 2'd3
    } rsp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_CHK_RD,
        ST_CHK_LAST,
        ST_PLC_WR,
        ST_FIRE_RD,
        ST_FIRE_WR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/board_addr_step.sv
// Cell address generator: start coordinate (x, y) advanced by step cells
// along +x (vert=0) or +y (vert=1), mapped to y*10 + x.
// Ports: x, y (start), vert (direction), step (cell index), addr (RAM address).
module board_addr_step
    import board_sequencer_pkg::*;
(
    input  logic [3:0]        x,
    input  logic [3:0]        y,
    input  logic              vert,
    input  logic [2:0]        step,
    output logic [ADDR_W-1:0] addr
);
    logic [4:0] cx;
    logic [4:0] cy;

    assign cx = {1'b0, x} + (vert ? 5'd0 : {2'b00, step});
    assign cy = {1'b0, y} + (vert ? {2'b00, step} : 5'd0);

    // Multiply by ten as two shifts and an add.
    assign addr = ({5'd0, cy} << 3) + ({5'd0, cy} << 1) + {5'd0, cx};
endmodule

// File: rtl/board_sequencer.sv
// Command sequencer for a battleship board held in an external RAM.
// Executes CLEAR (wipe board), PLACE (overlap-checked ship placement) and
// FIRE (shot with hit/miss marking), tracking placed and hit cell counts.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_x/
// cmd_y/cmd_len/cmd_vert (command); rsp_valid/rsp_code (one-cycle result);
// ram_addr/ram_we/ram_wdata/ram_rdata (board RAM, 1-cycle read latency);
// busy (not IDLE); all_sunk (every placed cell hit).
module board_sequencer
    import board_sequencer_pkg::*;
#(
    parameter int BOARD_W = BOARD_W_DEF,
    parameter int BOARD_H = BOARD_H_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_x,
    input  logic [3:0]        cmd_y,
    input  logic [2:0]        cmd_len,
    input  logic              cmd_vert,
    output logic              rsp_valid,
    output logic [1:0]        rsp_code,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [1:0]        ram_wdata,
    input  logic [1:0]        ram_rdata,
    output logic              busy,
    output logic              all_sunk
);
    localparam logic [4:0]        W5        = 5'(BOARD_W);
    localparam logic [4:0]        H5        = 5'(BOARD_H);
    localparam logic [2:0]        LEN_MAX   = 3'(MAX_LEN);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BOARD_W * BOARD_H - 1);

    state_e            state;
    logic [3:0]        sx, sy;
    logic [2:0]        slen;
    logic              svert;
    logic [2:0]        step;
    logic [2:0]        step_sel;
    logic              bad;
    logic [6:0]        placed, hits;
    logic              we_reg;
    logic [1:0]        wdata_reg;
    logic [ADDR_W-1:0] cmd_addr, next_addr;
    logic              cmd_legal, place_legal, fire_write;

    // Address of the command's start cell, used on the accept cycle.
    board_addr_step u_cmd_addr (
        .x(cmd_x), .y(cmd_y), .vert(1'b0), .step(3'd0), .addr(cmd_addr)
    );

    // Address of the next cell of the captured ship; restarts at cell 0
    // when moving from the overlap check into the write pass.
    assign step_sel = (state == ST_CHK_LAST) ? 3'd0 : step + 3'd1;

    board_addr_step u_next_addr (
        .x(sx), .y(sy), .vert(svert), .step(step_sel), .addr(next_addr)
    );

    always_comb begin
        place_legal = (cmd_len != 3'd0) && (cmd_len <= LEN_MAX) &&
                      (cmd_vert ? ({1'b0, cmd_y} + {2'b00, cmd_len} <= H5)
                                : ({1'b0, cmd_x} + {2'b00, cmd_len} <= W5));
        cmd_legal   = (cmd_op != OP_RSVD) && ({1'b0, cmd_x} < W5) &&
                      ({1'b0, cmd_y} < H5) &&
                      ((cmd_op != OP_PLACE) || place_legal);
    end

    // NOTE: a FIRE must write on the same cycle its read data arrives, so
    // that one write is decoded combinationally from ram_rdata; every other
    // write strobe comes straight from a register.
    assign fire_write = (state == ST_FIRE_WR) &&
                        (ram_rdata == TILE_EMPTY || ram_rdata == TILE_SHIP);
    assign ram_we     = we_reg | fire_write;
    assign ram_wdata  = fire_write ? ((ram_rdata == TILE_SHIP) ? TILE_HIT : TILE_MISS)
                                   : wdata_reg;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    // NOTE: the board RAM is external and deliberately untouched by rst;
    // only this block's control state and counters are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_code  <= RSP_DONE;
            ram_addr  <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= TILE_EMPTY;
            sx        <= '0;
            sy        <= '0;
            slen      <= '0;
            svert     <= 1'b0;
            step      <= '0;
            bad       <= 1'b0;
            placed    <= '0;
            hits      <= '0;
            all_sunk  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            all_sunk  <= (placed != 7'd0) && (hits == placed);
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    sx    <= cmd_x;
                    sy    <= cmd_y;
                    slen  <= cmd_len;
                    svert <= cmd_vert;
                    step  <= '0;
                    bad   <= 1'b0;
                    if (!cmd_legal) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_ERROR;
                    end else if (cmd_op == OP_CLEAR) begin
                        state     <= ST_CLR;
                        ram_addr  <= '0;
                        we_reg    <= 1'b1;
                        wdata_reg <= TILE_EMPTY;
                        placed    <= '0;
                        hits      <= '0;
                    end else begin
                        state    <= (cmd_op == OP_PLACE) ? ST_CHK_RD : ST_FIRE_RD;
                        ram_addr <= cmd_addr;
                    end
                end
                ST_CLR: begin
                    if (ram_addr == LAST_CELL) begin
                        we_reg    <= 1'b0;
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_DONE;
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                ST_CHK_RD: begin
                    // Data for the previous step's address arrives now.
                    if (step != 3'd0 && ram_rdata != TILE_EMPTY)
                        bad <= 1'b1;
                    if (step == slen - 3'd1) begin
                        state <= ST_CHK_LAST;
                    end else begin
                        step     <= step + 3'd1;
                        ram_addr <= next_addr;
                    end
                end
                ST_CHK_LAST: begin
                    if (bad || ram_rdata != TILE_EMPTY) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_ERROR;
                    end else begin
                        state     <= ST_PLC_WR;
                        step      <= '0;
                        ram_addr  <= next_addr;
                        we_reg    <= 1'b1;
                        wdata_reg <= TILE_SHIP;
                    end
                end
                ST_PLC_WR: begin
                    if (step == slen - 3'd1) begin
                        we_reg    <= 1'b0;
                        placed    <= placed + {4'd0, slen};
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_code  <= RSP_DONE;
                    end else begin
                        step     <= step + 3'd1;
                        ram_addr <= next_addr;
                    end
                end
                ST_FIRE_RD: state <= ST_FIRE_WR;
                ST_FIRE_WR: begin
                    state     <= ST_RESP;
                    rsp_valid <= 1'b1;
                    if (ram_rdata == TILE_SHIP) begin
                        rsp_code <= RSP_HIT;
                        hits     <= hits + 7'd1;
                    end else if (ram_rdata == TILE_EMPTY) begin
                        rsp_code <= RSP_MISS;
                    end else begin
                        rsp_code <= RSP_ERROR;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_sequencer.sv
// Directed testbench for board_sequencer with a behavioural board RAM
// (synchronous write, one-cycle registered read).
module tb_board_sequencer;
    import board_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_x, cmd_y;
    logic [2:0]  cmd_len;
    logic        cmd_vert;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [1:0]  ram_wdata;
    logic [1:0]  ram_rdata;
    logic        busy;
    logic        all_sunk;

    int n_cmp = 0;
    int n_bad = 0;

    board_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_vert(cmd_vert),
        .rsp_valid(rsp_valid), .rsp_code(rsp_code),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    logic [1:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Per-command record filled by run_cmd.
    int         rsp_cyc;
    logic [1:0] rsp_c;
    int         wr_addr[$];
    int         wr_data[$];
    int         wr_cyc[$];
    int         addr_at[0:255];

    task automatic run_cmd(input logic [1:0] op, input int x, input int y,
                           input int len, input logic vert);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_len   = 3'(len);
        cmd_vert  = vert;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        rsp_cyc = -1;
        rsp_c   = 2'd0;
        for (int c = 1; c <= 250; c++) begin
            @(negedge clk);
            addr_at[c] = int'(ram_addr);
            if (ram_we) begin
                wr_addr.push_back(int'(ram_addr));
                wr_data.push_back(int'(ram_wdata));
                wr_cyc.push_back(c);
            end
            if (rsp_valid) begin
                rsp_cyc = c;
                rsp_c   = rsp_code;
                break;
            end
        end
        n_cmp++;
        if (rsp_cyc < 0) begin
            n_bad++;
            $display("FAIL rsp_timeout: no rsp_valid within 250 cycles (op %0d)", op);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_x = '0; cmd_y = '0; cmd_len = '0; cmd_vert = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = TILE_MISS;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", ram_we); end
        n_cmp++; if (ram_addr !== 10'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", ram_addr); end
        n_cmp++; if (all_sunk !== 1'b0) begin n_bad++; $display("FAIL reset_all_sunk: got %b want 0", all_sunk); end
        rst = 1'b0;
    endtask

    task automatic test_clear;
        int errs = 0;
        run_cmd(OP_CLEAR, 0, 0, 0, 1'b0);
        n_cmp++; if (rsp_cyc != 101 || rsp_c !== RSP_DONE) begin n_bad++; $display("FAIL clear_rsp: got cycle %0d code %0d want 101/0", rsp_cyc, rsp_c); end
        n_cmp++; if (wr_addr.size() != 100) begin n_bad++; $display("FAIL clear_count: got %0d writes want 100", wr_addr.size()); end
        foreach (wr_addr[i]) if (wr_addr[i] != i || wr_data[i] != 0 || wr_cyc[i] != i + 1) errs++;
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL clear_pattern: got %0d bad writes want 0", errs); end
        n_cmp++; if (all_sunk !== 1'b0) begin n_bad++; $display("FAIL clear_all_sunk: got %b want 0", all_sunk); end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL clear_ready_after: got %b want 1", cmd_ready); end
    endtask

    task automatic test_place;
        int errs = 0;
        run_cmd(OP_PLACE, 2, 3, 4, 1'b0);
        n_cmp++; if (rsp_cyc != 10 || rsp_c !== RSP_DONE) begin n_bad++; $display("FAIL place_rsp: got cycle %0d code %0d want 10/0", rsp_cyc, rsp_c); end
        for (int i = 0; i < 4; i++) if (addr_at[i + 1] != 32 + i) errs++;
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL place_reads: got %0d bad read addresses want 0", errs); end
        errs = 0;
        if (wr_addr.size() != 4) errs = 99;
        else foreach (wr_addr[i]) if (wr_addr[i] != 32 + i || wr_data[i] != 3 || wr_cyc[i] != 6 + i) errs++;
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL place_writes: got %0d bad writes (n=%0d) want 0", errs, wr_addr.size()); end
    endtask

    task automatic test_errors;
        // op, x, y, len, vert: each must be rejected at cycle 1
        int tbl [6][5] = '{'{1, 7, 0, 4, 0}, '{1, 0, 0, 0, 0}, '{1, 0, 0, 6, 0},
                           '{2, 10, 0, 0, 0}, '{3, 0, 0, 1, 0}, '{1, 0, 8, 3, 1}};
        for (int t = 0; t < 6; t++) begin
            run_cmd(2'(tbl[t][0]), tbl[t][1], tbl[t][2], tbl[t][3], 1'(tbl[t][4]));
            n_cmp++; if (rsp_cyc != 1 || rsp_c !== RSP_ERROR || wr_addr.size() != 0) begin
                n_bad++; $display("FAIL err_case%0d: got cycle %0d code %0d writes %0d want 1/3/0", t, rsp_cyc, rsp_c, wr_addr.size());
            end
        end
        @(negedge clk);
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL err_back_to_back: got ready %b want 1", cmd_ready); end
        run_cmd(OP_PLACE, 3, 1, 3, 1'b1);
        n_cmp++; if (rsp_cyc != 5 || rsp_c !== RSP_ERROR || wr_addr.size() != 0) begin
            n_bad++; $display("FAIL overlap: got cycle %0d code %0d writes %0d want 5/3/0", rsp_cyc, rsp_c, wr_addr.size());
        end
    endtask

    task automatic test_fire;
        run_cmd(OP_FIRE, 2, 3, 0, 1'b0);
        n_cmp++; if (rsp_cyc != 3 || rsp_c !== RSP_HIT) begin n_bad++; $display("FAIL fire_hit_rsp: got cycle %0d code %0d want 3/1", rsp_cyc, rsp_c); end
        n_cmp++; if (wr_addr.size() != 1 || wr_addr[0] != 32 || wr_data[0] != 1 || wr_cyc[0] != 2) begin
            n_bad++; $display("FAIL fire_hit_write: got %0d writes want one HIT to 32 at cycle 2", wr_addr.size());
        end
        run_cmd(OP_FIRE, 2, 3, 0, 1'b0);
        n_cmp++; if (rsp_cyc != 3 || rsp_c !== RSP_ERROR || wr_addr.size() != 0) begin
            n_bad++; $display("FAIL fire_repeat: got cycle %0d code %0d writes %0d want 3/3/0", rsp_cyc, rsp_c, wr_addr.size());
        end
        run_cmd(OP_FIRE, 0, 0, 0, 1'b0);
        n_cmp++; if (rsp_c !== RSP_MISS || wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] != 2) begin
            n_bad++; $display("FAIL fire_miss: got code %0d writes %0d want MISS written to 0", rsp_c, wr_addr.size());
        end
    endtask

    task automatic test_sink;
        for (int x = 3; x <= 5; x++) begin
            run_cmd(OP_FIRE, x, 3, 0, 1'b0);
            n_cmp++; if (rsp_c !== RSP_HIT) begin n_bad++; $display("FAIL sink_hit_x%0d: got code %0d want 1", x, rsp_c); end
        end
        n_cmp++; if (all_sunk !== 1'b0) begin n_bad++; $display("FAIL sink_early: got %b want 0", all_sunk); end
        @(negedge clk);
        n_cmp++; if (all_sunk !== 1'b1) begin n_bad++; $display("FAIL sink_rise: got %b want 1", all_sunk); end
        run_cmd(OP_CLEAR, 0, 0, 0, 1'b0);
        n_cmp++; if (all_sunk !== 1'b0) begin n_bad++; $display("FAIL sink_clear: got %b want 0", all_sunk); end
    endtask

    task automatic test_boundary;
        int errs = 0;
        run_cmd(OP_PLACE, 5, 9, 5, 1'b0);
        n_cmp++; if (rsp_cyc != 12 || rsp_c !== RSP_DONE) begin n_bad++; $display("FAIL edge_place: got cycle %0d code %0d want 12/0", rsp_cyc, rsp_c); end
        if (wr_addr.size() != 5) errs = 99;
        else foreach (wr_addr[i]) if (wr_addr[i] != 95 + i || wr_data[i] != 3) errs++;
        n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL edge_writes: got %0d bad writes want 0", errs); end
        run_cmd(OP_PLACE, 6, 9, 5, 1'b0);
        n_cmp++; if (rsp_cyc != 1 || rsp_c !== RSP_ERROR) begin n_bad++; $display("FAIL edge_overrun: got cycle %0d code %0d want 1/3", rsp_cyc, rsp_c); end
        run_cmd(OP_PLACE, 9, 5, 5, 1'b1);
        n_cmp++; if (rsp_cyc != 7 || rsp_c !== RSP_ERROR || wr_addr.size() != 0) begin
            n_bad++; $display("FAIL edge_vert_overlap: got cycle %0d code %0d writes %0d want 7/3/0", rsp_cyc, rsp_c, wr_addr.size());
        end
    endtask

    task automatic test_reset_mid;
        int stray = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_CLEAR;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 50; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram_we !== 1'b0) begin n_bad++; $display("FAIL midrst_we: got %b want 0", ram_we); end
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got ready %b busy %b want 1/0", cmd_ready, busy); end
        rst = 1'b0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (rsp_valid || ram_we) stray++;
        end
        n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL midrst_stray: got %0d active cycles want 0", stray); end
        n_cmp++; if (mem[97] !== TILE_SHIP) begin n_bad++; $display("FAIL midrst_ram_kept: got %0d want 3", mem[97]); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_place();
        test_errors();
        test_fire();
        test_sink();
        test_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/board_sequencer.md
BOARD_SEQUENCER -- requirements
Module: board_sequencer

Interface
REQ-001 Parameter BOARD_W, default 10, meaning board columns.
REQ-002 Parameter BOARD_H, default 10, meaning board rows.
REQ-003 Parameter MAX_LEN, default 5, meaning longest legal ship.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command request.
REQ-007 cmd_ready  out  1  block can accept a command.
REQ-008 cmd_op  in  2  command: 00 CLEAR, 01 PLACE, 10 FIRE, 11 reserved.
REQ-009 cmd_x  in  4  column.
REQ-010 cmd_y  in  4  row.
REQ-011 cmd_len  in  3  ship length (PLACE only).
REQ-012 cmd_vert  in  1  1 = ship extends +y, 0 = ship extends +x (PLACE only).
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_code  out  2  result: 0 DONE, 1 HIT, 2 MISS, 3 ERROR; valid only with rsp_valid.
REQ-015 ram_addr  out  10  board RAM write/read port address.
REQ-016 ram_we  out  1  board RAM write enable.
REQ-017 ram_wdata  out  2  tile code to write.
REQ-018 ram_rdata  in  2  tile code; valid one cycle after ram_addr is driven.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 all_sunk  out  1  every placed ship cell has been hit.

Function
REQ-021 Tile codes SHALL be EMPTY=0, HIT=1, MISS=2, SHIP=3; the video port reads the same RAM independently.
REQ-022 ram_addr SHALL be y*BOARD_W+x, computed as (y<<3)+(y<<1)+x, zero-extended to 10 bits.
REQ-023 A command SHALL be accepted on the cycle cmd_valid&&cmd_ready (cycle 0); all cmd_* fields are captured then.
REQ-024 cmd_ready SHALL be high only in IDLE; rsp_valid is driven from the RESP state, so the earliest next acceptance is the cycle after rsp_valid.
REQ-025 FSM states: IDLE, CLR, CHK_RD, CHK_LAST, PLC_WR, FIRE_RD, FIRE_WR, RESP.
REQ-026 Reserved op, x>=BOARD_W or y>=BOARD_H SHALL give ERROR at cycle 1 with no RAM access.
REQ-027 PLACE SHALL also give ERROR at cycle 1 if len==0, len>MAX_LEN, or (start + len) exceeds the board in the ship direction.
REQ-028 CLEAR SHALL write EMPTY to addresses 0..99 on cycles 1..100, then DONE at cycle 101.
REQ-029 CLEAR SHALL zero both the placed-cell and hit counters.
REQ-030 PLACE (len L) SHALL read its L cells on cycles 1..L; data returns on cycles 2..L+1.
REQ-031 If any PLACE read is not EMPTY: ERROR at cycle L+2 and no writes.
REQ-032 Otherwise PLACE SHALL write SHIP to the L cells on cycles L+2..2L+1, add L to the placed counter, and give DONE at cycle 2L+2.
REQ-033 FIRE SHALL drive its read address on cycle 1 and sample ram_rdata on cycle 2.
REQ-034 FIRE on EMPTY: write MISS on cycle 2, MISS at cycle 3.
REQ-035 FIRE on SHIP: write HIT on cycle 2, increment the hit counter, HIT at cycle 3.
REQ-036 FIRE on HIT or MISS (repeat shot): no write, ERROR at cycle 3.
REQ-037 Placed counter is 7 bits and hit counter is 7 bits; neither exceeds 100 by construction.
REQ-038 all_sunk SHALL equal (placed!=0)&&(hits==placed), registered.
REQ-039 ram_we SHALL be high only on the write cycles defined above; ram_wdata is don't-care otherwise.

Reset
REQ-040 rst SHALL force IDLE, cmd_ready=1, rsp_valid=0, ram_we=0, ram_addr=0, busy=0, counters=0, all_sunk=0.
REQ-041 rst mid-command SHALL abort with no further writes and no response pulse.
REQ-042 RAM contents SHALL NOT be altered by rst; software issues CLEAR.

Structure
REQ-043 A shared package/header SHALL hold tile codes, op codes, rsp codes and board dimensions, also used by dynamic_screen.
REQ-044 One sub-module, board_addr_step, SHALL produce the cell address from a start coordinate, direction and step index.

Verification
REQ-045 CLEAR from reset -> 100 writes of 0 to addresses 0..99 on cycles 1..100, then rsp DONE at cycle 101, all_sunk=0.
REQ-046 PLACE x=2,y=3,len=4,vert=0 on a cleared board -> reads of 32..35, writes SHIP to 32..35 on cycles 6..9, then DONE at cycle 10.
REQ-047 PLACE x=7,y=0,len=4,vert=0 -> ERROR at cycle 1, no RAM access; PLACE x=3,y=1,len=3,vert=1 overlapping cell 33 -> ERROR at cycle 5, no writes.
REQ-048 FIRE (2,3) after REQ-046 -> write HIT to addr 32, rsp HIT; FIRE (2,3) again -> ERROR, no write; FIRE (0,0) -> MISS written to addr 0.
REQ-049 FIRE all four cells of the REQ-046 ship -> all_sunk rises the cycle after the fourth HIT; a following CLEAR drops it.
REQ-050 rst asserted on cycle 50 of CLEAR -> ram_we low from the next cycle, no rsp_valid, and cmd_ready=1 the cycle after.
